// File: rtl/unidad_de_control_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unidad_de_control_pkg                                                      |
// | Shared opcodes, state encoding, LE encodings and instruction fields.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package unidad_de_control_pkg;

  localparam int c_ANCHO_INSTR = 16;

  localparam logic [3:0] c_OP_NOP  = 4'h0;
  localparam logic [3:0] c_OP_LDI  = 4'h1;
  localparam logic [3:0] c_OP_MOV  = 4'h2;
  localparam logic [3:0] c_OP_ALU  = 4'h3;
  localparam logic [3:0] c_OP_OUT  = 4'h4;
  localparam logic [3:0] c_OP_JMP  = 4'h5;
  localparam logic [3:0] c_OP_JZ   = 4'h6;
  localparam logic [3:0] c_OP_HALT = 4'hF;

  localparam logic [2:0] c_ST_BUSCAR      = 3'd0;
  localparam logic [2:0] c_ST_DECODIFICAR = 3'd1;
  localparam logic [2:0] c_ST_EJECUTAR    = 3'd2;
  localparam logic [2:0] c_ST_ESCRITURA   = 3'd3;
  localparam logic [2:0] c_ST_DETENIDO    = 3'd4;

  localparam logic [1:0] c_LE_IDLE     = 2'b00;
  localparam logic [1:0] c_LE_ESCRIBIR = 2'b01;
  localparam logic [1:0] c_LE_LEER     = 2'b10;
  localparam logic [1:0] c_LE_COPIAR   = 2'b11;

  localparam int c_OP_MSB  = 15;
  localparam int c_OP_LSB  = 12;
  localparam int c_RD_MSB  = 11;
  localparam int c_RD_LSB  = 9;
  localparam int c_RX_MSB  = 8;
  localparam int c_RX_LSB  = 6;
  localparam int c_RY_MSB  = 5;
  localparam int c_RY_LSB  = 3;
  localparam int c_IMM_MSB = 7;
  localparam int c_IMM_LSB = 0;

  typedef struct packed {
    logic [2:0] rd;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] imm;
    logic       es_ldi;
    logic       es_mov;
    logic       es_alu;
    logic       es_out;
    logic       es_jmp;
    logic       es_jz;
    logic       es_halt;
    logic       ilegal;
  } decod_t;

endpackage
`default_nettype wire

// File: rtl/unidad_de_control_decodificador_instruccion.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decodificador_instruccion                                                  |
// | Combinational opcode/field decode; JZ legal only with                      |
// | UNIDAD_CONTROL_SALTO_COND_EN defined.                                      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module decodificador_instruccion
  import unidad_de_control_pkg::*;
(
  input  logic [c_ANCHO_INSTR-1:0] i_Instruccion,
  output decod_t                   o_Decod
);

  always_comb begin
    o_Decod     = '0;
    o_Decod.rd  = i_Instruccion[c_RD_MSB:c_RD_LSB];
    o_Decod.rx  = i_Instruccion[c_RX_MSB:c_RX_LSB];
    o_Decod.ry  = i_Instruccion[c_RY_MSB:c_RY_LSB];
    o_Decod.imm = i_Instruccion[c_IMM_MSB:c_IMM_LSB];
    case (i_Instruccion[c_OP_MSB:c_OP_LSB])
      c_OP_NOP:  o_Decod.ilegal  = 1'b0;
      c_OP_LDI:  o_Decod.es_ldi  = 1'b1;
      c_OP_MOV:  o_Decod.es_mov  = 1'b1;
      c_OP_ALU:  o_Decod.es_alu  = 1'b1;
      c_OP_OUT:  o_Decod.es_out  = 1'b1;
      c_OP_JMP:  o_Decod.es_jmp  = 1'b1;
`ifdef UNIDAD_CONTROL_SALTO_COND_EN
      c_OP_JZ:   o_Decod.es_jz   = 1'b1;
`else
      c_OP_JZ:   o_Decod.ilegal  = 1'b1;
`endif
      c_OP_HALT: o_Decod.es_halt = 1'b1;
      default:   o_Decod.ilegal  = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/unidad_de_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | unidad_de_control                                                          |
// | Fetch/decode/execute sequencer driving the register file; owns PC and halt.|
// | Optional JZ support: UNIDAD_CONTROL_SALTO_COND_EN.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module unidad_de_control
  import unidad_de_control_pkg::*;
#(
  parameter int ANCHO_DATOS = 8,
  parameter int ANCHO_PC    = 8
) (
  input  logic                     i_Timming,
  input  logic                     i_Rst,
  input  logic [c_ANCHO_INSTR-1:0] i_Instruccion,
  input  logic                     i_Fetch_ack,
  input  logic [ANCHO_DATOS-1:0]   i_Resultado_ALU,
  input  logic                     i_Cero,
  output logic                     o_Fetch_req,
  output logic [ANCHO_PC-1:0]      o_PC,
  output logic [ANCHO_DATOS-1:0]   o_Datos,
  output logic [1:0]               o_Lectura_escritura,
  output logic [2:0]               o_Control_RX,
  output logic [2:0]               o_Control_RY,
  output logic [2:0]               o_Seleccion_registro_escritura,
  output logic [2:0]               o_Seleccion_registro_lectura,
  output logic                     o_Ilegal,
  output logic                     o_Detenido
);

  logic [2:0]               r_estado;
  logic [2:0]               w_estado_sig;
  logic [c_ANCHO_INSTR-1:0] r_instr;
  logic [c_ANCHO_INSTR-1:0] w_instr;
  decod_t                   w_dec;

  logic                     r_fetch_req, w_fetch_req;
  logic [ANCHO_PC-1:0]      r_pc, w_pc;
  logic [ANCHO_DATOS-1:0]   r_datos, w_datos;
  logic [1:0]               r_le, w_le;
  logic [2:0]               r_rx, w_rx;
  logic [2:0]               r_ry, w_ry;
  logic [2:0]               r_esc, w_esc;
  logic [2:0]               r_lect, w_lect;
  logic                     r_ilegal, w_ilegal;
  logic                     r_detenido, w_detenido;

  logic                     w_ack_valido;
  logic                     w_salto_tomado;

  // An ack only counts while our own request is up.
  assign w_ack_valido   = r_fetch_req & i_Fetch_ack;
  assign w_salto_tomado = w_dec.es_jmp | (w_dec.es_jz & i_Cero);

  decodificador_instruccion u_decodificador (
    .i_Instruccion (r_instr),
    .o_Decod       (w_dec)
  );

  always_ff @(posedge i_Timming) begin
    if (i_Rst) begin
      r_estado <= c_ST_BUSCAR;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      c_ST_BUSCAR:      if (w_ack_valido) w_estado_sig = c_ST_DECODIFICAR;
      c_ST_DECODIFICAR: w_estado_sig = c_ST_EJECUTAR;
      c_ST_EJECUTAR: begin
        if (w_dec.es_halt)     w_estado_sig = c_ST_DETENIDO;
        else if (w_dec.es_alu) w_estado_sig = c_ST_ESCRITURA;
        else                   w_estado_sig = c_ST_BUSCAR;
      end
      c_ST_ESCRITURA:   w_estado_sig = c_ST_BUSCAR;
      c_ST_DETENIDO:    w_estado_sig = c_ST_DETENIDO;
      default:          w_estado_sig = c_ST_BUSCAR;
    endcase
  end

  // Outputs are registered, so each is computed from the state being entered.
  always_comb begin
    w_fetch_req = (w_estado_sig == c_ST_BUSCAR);
    w_detenido  = (w_estado_sig == c_ST_DETENIDO);
    w_le        = c_LE_IDLE;
    w_ilegal    = 1'b0;
    w_instr     = r_instr;
    w_pc        = r_pc;
    w_datos     = r_datos;
    w_rx        = r_rx;
    w_ry        = r_ry;
    w_esc       = r_esc;
    w_lect      = r_lect;
    case (r_estado)
      c_ST_BUSCAR: begin
        if (w_ack_valido) w_instr = i_Instruccion;
      end
      c_ST_DECODIFICAR: begin
        w_ilegal = w_dec.ilegal;
        if (w_dec.es_ldi) begin
          w_le    = c_LE_ESCRIBIR;
          w_datos = ANCHO_DATOS'(w_dec.imm);
          w_esc   = w_dec.rd;
        end else if (w_dec.es_mov) begin
          w_le    = c_LE_COPIAR;
          w_lect  = w_dec.rx;
          w_esc   = w_dec.rd;
        end else if (w_dec.es_alu) begin
          w_rx    = w_dec.rx;
          w_ry    = w_dec.ry;
        end else if (w_dec.es_out) begin
          w_le    = c_LE_LEER;
          w_lect  = w_dec.rx;
        end
      end
      c_ST_EJECUTAR: begin
        if (w_dec.es_alu) begin
          w_le    = c_LE_ESCRIBIR;
          w_datos = i_Resultado_ALU;
          w_esc   = w_dec.rd;
        end else if (w_salto_tomado) begin
          w_pc    = ANCHO_PC'(w_dec.imm);
        end else if (!w_dec.es_halt) begin
          w_pc    = r_pc + ANCHO_PC'(1);
        end
      end
      c_ST_ESCRITURA: begin
        w_pc = r_pc + ANCHO_PC'(1);
      end
      default: w_le = c_LE_IDLE;
    endcase
  end

  always_ff @(posedge i_Timming) begin
    if (i_Rst) begin
      r_instr    <= '0;
      r_fetch_req <= 1'b0;
      r_pc       <= '0;
      r_datos    <= '0;
      r_le       <= c_LE_IDLE;
      r_rx       <= '0;
      r_ry       <= '0;
      r_esc      <= '0;
      r_lect     <= '0;
      r_ilegal   <= 1'b0;
      r_detenido <= 1'b0;
    end else begin
      r_instr    <= w_instr;
      r_fetch_req <= w_fetch_req;
      r_pc       <= w_pc;
      r_datos    <= w_datos;
      r_le       <= w_le;
      r_rx       <= w_rx;
      r_ry       <= w_ry;
      r_esc      <= w_esc;
      r_lect     <= w_lect;
      r_ilegal   <= w_ilegal;
      r_detenido <= w_detenido;
    end
  end

  assign o_Fetch_req                    = r_fetch_req;
  assign o_PC                           = r_pc;
  assign o_Datos                        = r_datos;
  assign o_Lectura_escritura            = r_le;
  assign o_Control_RX                   = r_rx;
  assign o_Control_RY                   = r_ry;
  assign o_Seleccion_registro_escritura = r_esc;
  assign o_Seleccion_registro_lectura   = r_lect;
  assign o_Ilegal                       = r_ilegal;
  assign o_Detenido                     = r_detenido;

endmodule
`default_nettype wire
